// File: rtl/knight_rider_ctrl.sv
// knight_rider_ctrl: 8-LED "Knight Rider" scanner with two debounced push buttons.
//
// Parameters:
//   DEB_CNT  - cycles a synchronized button level must hold before it is accepted (>= 2)
//   BASE_DIV - step period in cycles at rate index 0 (>= 16, fits in 24 bits)
//
// Ports:
//   clk             in   single clock, rising edge
//   rst             in   asynchronous active-low reset
//   rate_ctrl       in   raw rate button (asynchronous, bouncy)
//   brightness_ctrl in   raw brightness button (asynchronous, bouncy)
//   leds[7:0]       out  registered LED drive, bit n = LED n
//   pos[2:0]        out  scanner head position
//   dir             out  scan direction, 0 = up, 1 = down
//   rate_idx[1:0]   out  rate setting; step period = BASE_DIV >> rate_idx
//   bright_lvl[2:0] out  head brightness; duty = (bright_lvl + 1) / 8
//
// Optional feature: define KR_CTRL_TRAIL_EN to add a dim trailing LED at the previous
// head position. Without it only the head is shown.
module knight_rider_ctrl #(
    parameter int unsigned DEB_CNT  = 1000,
    parameter int unsigned BASE_DIV = 250000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rate_ctrl,
    input  logic       brightness_ctrl,
    output logic [7:0] leds,
    output logic [2:0] pos,
    output logic       dir,
    output logic [1:0] rate_idx,
    output logic [2:0] bright_lvl
);

    localparam int unsigned DebW = $clog2(DEB_CNT);
    localparam logic [DebW-1:0] DebMax = DebW'(DEB_CNT - 1);
    localparam logic [23:0] BaseDiv = 24'(BASE_DIV);

    typedef enum logic {StUp, StDown} dir_e;

    // Button vectors: bit 0 = rate, bit 1 = brightness.
    logic [1:0]            sync0_q, sync1_q;
    logic [1:0]            stable_q, stable_d;
    logic [1:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;
    logic [1:0]            press;

    logic [23:0] presc_q, presc_d;
    logic [23:0] period_m1;
    logic        step;

    logic [2:0]  pwm_q, pwm_d;
    logic [1:0]  rate_idx_q, rate_idx_d;
    logic [2:0]  bright_lvl_q, bright_lvl_d;
    logic [2:0]  pos_q, pos_d;
    dir_e        dir_q, dir_d;
    logic [7:0]  leds_q, leds_d;

    // Debounce: count while the synced level differs from the accepted one; a rising
    // acceptance is the press pulse, emitted in the same cycle stable updates.
    always_comb begin
        stable_d  = stable_q;
        deb_cnt_d = '0;
        press     = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync1_q[i] != stable_q[i]) begin
                if (deb_cnt_q[i] == DebMax) begin
                    stable_d[i] = sync1_q[i];
                    press[i]    = sync1_q[i];
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Step uses the period of the rate in force before any press in this cycle.
    assign period_m1 = (BaseDiv >> rate_idx_q) - 24'd1;
    assign step      = (presc_q == period_m1);

    always_comb begin
        presc_d = presc_q + 24'd1;
        if (press[0] || step) begin
            presc_d = '0;
        end
    end

    always_comb begin
        rate_idx_d   = rate_idx_q;
        bright_lvl_d = bright_lvl_q;
        if (press[0]) begin
            rate_idx_d = rate_idx_q + 2'd1;
        end
        if (press[1]) begin
            bright_lvl_d = bright_lvl_q + 3'd1;
        end
    end

    assign pwm_d = pwm_q + 3'd1;

    // Scan FSM: direction is the state, position bounces between 0 and 7.
    always_comb begin
        dir_d = dir_q;
        pos_d = pos_q;
        if (step) begin
            unique case (dir_q)
                StUp: begin
                    if (pos_q == 3'd7) begin
                        dir_d = StDown;
                        pos_d = 3'd6;
                    end else begin
                        pos_d = pos_q + 3'd1;
                    end
                end
                StDown: begin
                    if (pos_q == 3'd0) begin
                        dir_d = StUp;
                        pos_d = 3'd1;
                    end else begin
                        pos_d = pos_q - 3'd1;
                    end
                end
            endcase
        end
    end

`ifdef KR_CTRL_TRAIL_EN
    logic [2:0] prev_pos_q, prev_pos_d;

    assign prev_pos_d = step ? pos_q : prev_pos_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_pos_q <= '0;
        end else begin
            prev_pos_q <= prev_pos_d;
        end
    end

    // Trail is lit only in PWM slot 0 (1/8 duty) and never on top of the head.
    always_comb begin
        leds_d = '0;
        if (pwm_q <= bright_lvl_q) begin
            leds_d = 8'd1 << pos_q;
        end
        if ((pwm_q == 3'd0) && (prev_pos_q != pos_q)) begin
            leds_d = leds_d | (8'd1 << prev_pos_q);
        end
    end
`else
    always_comb begin
        leds_d = '0;
        if (pwm_q <= bright_lvl_q) begin
            leds_d = 8'd1 << pos_q;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0_q      <= '0;
            sync1_q      <= '0;
            stable_q     <= '0;
            deb_cnt_q    <= '0;
            presc_q      <= '0;
            pwm_q        <= '0;
            rate_idx_q   <= '0;
            bright_lvl_q <= 3'd7;
            pos_q        <= '0;
            dir_q        <= StUp;
            leds_q       <= '0;
        end else begin
            sync0_q      <= {brightness_ctrl, rate_ctrl};
            sync1_q      <= sync0_q;
            stable_q     <= stable_d;
            deb_cnt_q    <= deb_cnt_d;
            presc_q      <= presc_d;
            pwm_q        <= pwm_d;
            rate_idx_q   <= rate_idx_d;
            bright_lvl_q <= bright_lvl_d;
            pos_q        <= pos_d;
            dir_q        <= dir_d;
            leds_q       <= leds_d;
        end
    end

    assign leds       = leds_q;
    assign pos        = pos_q;
    assign dir        = (dir_q == StDown);
    assign rate_idx   = rate_idx_q;
    assign bright_lvl = bright_lvl_q;

endmodule

// File: tb/tb_knight_rider_ctrl.sv
// Scoreboard bench for knight_rider_ctrl (DEB_CNT=4, BASE_DIV=16). Stimulus pushes
// expected output values tagged with the cycle they are due; a monitor compares them
// on the falling edge (or immediately when kicked, for asynchronous reset checks).
module tb_knight_rider_ctrl;

    localparam int unsigned Deb  = 4;
    localparam int unsigned Base = 16;
`ifdef KR_CTRL_TRAIL_EN
    localparam bit Trail = 1'b1;
`else
    localparam bit Trail = 1'b0;
`endif

    localparam int KLeds = 0;
    localparam int KPos = 1;
    localparam int KDir = 2;
    localparam int KRate = 3;
    localparam int KBright = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rate_ctrl = 1'b0;
    logic       brightness_ctrl = 1'b0;
    logic [7:0] leds;
    logic [2:0] pos;
    logic       dir;
    logic [1:0] rate_idx;
    logic [2:0] bright_lvl;

    knight_rider_ctrl #(
        .DEB_CNT (Deb),
        .BASE_DIV(Base)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rate_ctrl      (rate_ctrl),
        .brightness_ctrl(brightness_ctrl),
        .leds           (leds),
        .pos            (pos),
        .dir            (dir),
        .rate_idx       (rate_idx),
        .bright_lvl     (bright_lvl)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int    due;
        int    kind;
        int    exp;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;
    logic kick = 1'b0;

    task automatic expect_at(input int due, input int kind, input int exp, input string tag);
        exp_t e;
        e.due  = due;
        e.kind = kind;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic check_item(input exp_t e);
        int act;
        case (e.kind)
            KLeds:   act = int'(leds);
            KPos:    act = int'(pos);
            KDir:    act = int'(dir);
            KRate:   act = int'(rate_idx);
            default: act = int'(bright_lvl);
        endcase
        n_checks++;
        if (act != e.exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", e.tag, cyc, act, e.exp);
        end
    endtask

    // Monitor: compare every expectation that has come due.
    initial begin : monitor
        int i;
        forever begin
            @(negedge clk or posedge kick);
            i = 0;
            while (i < sb.size()) begin
                if (sb[i].due <= cyc) begin
                    check_item(sb[i]);
                    sb.delete(i);
                end else begin
                    i++;
                end
            end
        end
    end

    task automatic kick_monitor();
        kick = 1'b1;
        #1;
        kick = 1'b0;
    endtask

    task automatic expect_reset_state(input string tag);
        expect_at(cyc, KLeds, 8'h00, {tag, "_leds"});
        expect_at(cyc, KPos, 0, {tag, "_pos"});
        expect_at(cyc, KDir, 0, {tag, "_dir"});
        expect_at(cyc, KRate, 0, {tag, "_rate"});
        expect_at(cyc, KBright, 7, {tag, "_bright"});
        kick_monitor();
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Returns at the falling edge where rst rises; r = cycle number there.
    task automatic do_reset(output int r, input logic hold_rate);
        @(negedge clk);
        rst = 1'b0;
        rate_ctrl = hold_rate;
        brightness_ctrl = 1'b0;
        #2;
        expect_reset_state("rst");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        r = cyc;
    endtask

    // Clean 8-cycle press starting at the current falling edge S; pulse lands at S+6.
    task automatic press(input logic is_rate);
        if (is_rate) rate_ctrl = 1'b1;
        else brightness_ctrl = 1'b1;
        repeat (8) @(negedge clk);
        rate_ctrl = 1'b0;
        brightness_ctrl = 1'b0;
    endtask

    initial begin : watchdog
        repeat (3000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int r;

        // Release with no buttons: first step after 16 cycles.
        do_reset(r, 1'b0);
        expect_at(r + 1, KLeds, 8'h01, "first_leds");
        expect_at(r + 10, KRate, 0, "no_phantom_press");
        expect_at(r + 15, KPos, 0, "pos_before_step");
        expect_at(r + 16, KPos, 1, "pos_first_step");
        expect_at(r + 16, KLeds, 8'h01, "leds_lag");
        expect_at(r + 17, KLeds, Trail ? 8'h03 : 8'h02, "leds_after_step");
        wait_until(r + 18);

        // Short glitch ignored; a real press lands on a step edge; wrap after four.
        do_reset(r, 1'b0);
        rate_ctrl = 1'b1;
        wait_until(r + 3);
        rate_ctrl = 1'b0;
        expect_at(r + 8, KRate, 0, "glitch_ignored");
        wait_until(r + 10);
        expect_at(r + 15, KRate, 0, "rate_before_press");
        expect_at(r + 16, KRate, 1, "rate_press1");
        expect_at(r + 15, KPos, 0, "pos_pre_step_press");
        expect_at(r + 16, KPos, 1, "step_with_press");
        expect_at(r + 23, KPos, 1, "rate1_hold");
        expect_at(r + 24, KPos, 2, "rate1_step1");
        expect_at(r + 30, KRate, 1, "release_no_press");
        expect_at(r + 31, KPos, 2, "rate1_hold2");
        expect_at(r + 32, KPos, 3, "rate1_step2");
        press(1'b1);
        for (int k = 0; k < 3; k++) begin
            wait_until(r + 40 + 16 * k);
            expect_at(r + 45 + 16 * k, KRate, (k + 1) % 4, "rate_before_next");
            expect_at(r + 46 + 16 * k, KRate, (k + 2) % 4, "rate_next");
            press(1'b1);
        end
        wait_until(r + 80);

        // Full bounce sweep at the base rate.
        do_reset(r, 1'b0);
        expect_at(r + 111, KPos, 6, "sweep_pos6");
        expect_at(r + 112, KPos, 7, "sweep_pos7");
        expect_at(r + 112, KDir, 0, "sweep_dir_up");
        expect_at(r + 114, KLeds, 8'h80, "sweep_led7");
        expect_at(r + 128, KPos, 6, "turn_down_pos");
        expect_at(r + 128, KDir, 1, "turn_down_dir");
        expect_at(r + 224, KPos, 0, "sweep_pos0");
        expect_at(r + 224, KDir, 1, "sweep_dir_down");
        expect_at(r + 240, KPos, 1, "turn_up_pos");
        expect_at(r + 240, KDir, 0, "turn_up_dir");
        wait_until(r + 242);

        // Brightness 0: head lit one cycle in eight; second press on a step edge.
        do_reset(r, 1'b0);
        expect_at(r + 5, KBright, 7, "bright_before");
        expect_at(r + 6, KBright, 0, "bright_wrap");
        for (int k = 17; k <= 25; k++) begin
            expect_at(r + k, KLeds,
                      (k % 8 == 1) ? (Trail ? 8'h03 : 8'h02) : 8'h00, "pwm_duty");
        end
        press(1'b0);
        wait_until(r + 26);
        expect_at(r + 31, KPos, 1, "bpress_pre_step");
        expect_at(r + 32, KPos, 2, "bpress_step_on_time");
        expect_at(r + 31, KBright, 0, "bright_pre2");
        expect_at(r + 32, KBright, 1, "bright_press2");
        press(1'b0);
        wait_until(r + 34);

        // Asynchronous reset mid-scan at pos 5, rate 2.
        do_reset(r, 1'b0);
        expect_at(r + 6, KRate, 1, "rate_to1");
        expect_at(r + 14, KPos, 1, "r1_step");
        expect_at(r + 22, KPos, 2, "r1_step_with_press");
        expect_at(r + 22, KRate, 2, "rate_to2");
        expect_at(r + 26, KPos, 3, "r2_step");
        expect_at(r + 34, KPos, 5, "r2_pos5");
        expect_at(r + 34, KRate, 2, "r2_rate");
        press(1'b1);
        wait_until(r + 16);
        press(1'b1);
        wait_until(r + 34);
        #2;
        rst = 1'b0;
        #1;
        expect_reset_state("async_rst");

        // Trail after step 3->4 (bit 3 only in PWM slot 0, and only with the trail).
        do_reset(r, 1'b0);
        expect_at(r + 64, KPos, 4, "trail_pos4");
        for (int k = 65; k <= 72; k++) begin
            expect_at(r + k, KLeds,
                      (k % 8 == 1 && Trail) ? 8'h18 : 8'h10, "trail_leds");
        end
        wait_until(r + 74);

        // Button held through reset release: exactly one press, 2+DEB_CNT cycles later.
        do_reset(r, 1'b1);
        expect_at(r + 5, KRate, 0, "held_before");
        expect_at(r + 6, KRate, 1, "held_press");
        expect_at(r + 20, KRate, 1, "held_single");
        wait_until(r + 10);
        rate_ctrl = 1'b0;
        wait_until(r + 22);

        repeat (3) @(negedge clk);
        foreach (sb[i]) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: never compared (due cycle %0d, want 0x%0h)",
                     sb[i].tag, sb[i].due, sb[i].exp);
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/knight_rider_ctrl.md
KNIGHT_RIDER_CTRL -- requirements
Module: knight_rider_ctrl

Interface
REQ-001 SHALL have parameter DEB_CNT, default 1000, cycles an input must hold a new level before it is accepted (min 2).
REQ-002 SHALL have parameter BASE_DIV, default 250000, step period in cycles at rate index 0 (min 16, 24-bit max).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rate_ctrl  input  1  raw rate button, asynchronous, may bounce.
REQ-006 SHALL have port brightness_ctrl  input  1  raw brightness button, asynchronous, may bounce.
REQ-007 SHALL have port leds  output  8  registered LED drive, bit n = LED n.
REQ-008 SHALL have port pos  output  3  current scanner head position.
REQ-009 SHALL have port dir  output  1  scan direction, 0 = up (increasing pos), 1 = down.
REQ-010 SHALL have port rate_idx  output  2  current rate setting.
REQ-011 SHALL have port bright_lvl  output  3  current brightness setting.

Function
REQ-012 Each button SHALL pass a 2-FF synchronizer, then a debouncer: counter clears while synced value equals stable value; otherwise it increments, and at DEB_CNT-1 stable takes the synced value and the counter clears.
REQ-013 A 0->1 transition of a stable value SHALL produce a one-cycle press pulse; 1->0 SHALL produce nothing.
REQ-014 A rate press SHALL increment rate_idx modulo 4 (3 wraps to 0); a brightness press SHALL increment bright_lvl modulo 8 (7 wraps to 0).
REQ-015 Simultaneous rate and brightness presses SHALL both apply in the same cycle.
REQ-016 Step period SHALL be BASE_DIV >> rate_idx cycles; a prescaler counts 0..period-1 and issues a one-cycle step when it reaches period-1, then returns to 0.
REQ-017 A rate press SHALL clear the prescaler in the same cycle, so the first step at the new rate occurs exactly one new period later.
REQ-018 On step with dir=0: pos<7 increments pos; pos=7 sets dir=1 and pos=6.
REQ-019 On step with dir=1: pos>0 decrements pos; pos=0 sets dir=0 and pos=1.
REQ-020 A 3-bit free-running PWM counter SHALL wrap 7->0 every cycle; head is on when pwm_cnt <= bright_lvl (duty (lvl+1)/8; lvl 7 = always on).
REQ-021 leds SHALL be registered: next value = one-hot(pos) gated by head-on, ORed with the trail term of REQ-027; one-cycle latency from pos/pwm_cnt.
REQ-022 A press landing on the same cycle as a step SHALL not delay or drop that step.

Reset
REQ-023 While rst=0, asynchronously: leds=8'h00, pos=0, dir=0, rate_idx=0, bright_lvl=7, prescaler=0, pwm_cnt=0, debounce counters=0, stable values=0, synchronizers=0.
REQ-024 Reset asserted mid-operation SHALL discard pending steps and in-progress debounce counts; no press pulse SHALL result from reset release with a button already released.
REQ-025 A button held through reset release SHALL produce one press after 2+DEB_CNT cycles.

Configuration
REQ-026 Macro KR_CTRL_TRAIL_EN SHALL compile in a trailing LED; without it, the trail logic and prev-position register SHALL be absent and leds shows only the head.
REQ-027 With KR_CTRL_TRAIL_EN: prev_pos (reset 0) SHALL capture pos on every step; bit prev_pos is lit when pwm_cnt==0 and prev_pos!=pos.

Verification (DEB_CNT=4, BASE_DIV=16)
REQ-028 Reset then release, no buttons -> leds=00 during reset; pos=1 on the 16th cycle after release; leds=02 one cycle later.
REQ-029 rate_ctrl high for 3 cycles then low -> rate_idx stays 0; high for 8 cycles -> rate_idx=1, steps every 8 cycles; four presses total -> rate_idx=0.
REQ-030 Run 7 steps -> pos=7,dir=0; next step -> pos=6,dir=1; continue to pos=0 -> next step pos=1,dir=0.
REQ-031 One brightness press from reset -> bright_lvl=0, head bit high exactly 1 of every 8 cycles; press during step cycle -> step still occurs on time.
REQ-032 Drop rst at pos=5 with rate_idx=2 -> leds=00, pos=0, rate_idx=0, bright_lvl=7 immediately, without waiting for a clock edge.
REQ-033 With KR_CTRL_TRAIL_EN, after step 3->4 -> leds bit 3 lit only when pwm_cnt==0, bit 4 per bright_lvl; without the macro bit 3 never lit.
